param_reg_file: RTL and testbench
=================================

Name: param_reg_file

Overview:
- Parametrised successor to the single-cycle 32x32 register file.
- Provides two combinational read ports and one write port, with the write destination selected by RegDst.
- Write-back is suppressed when the ALU reports Overflow.
- New behaviour:
  - Width and depth are parameters.
  - Register 0 can be hardwired to zero.
  - Writes occur on the posedge.
  - A sequential post-reset clear engine with a Ready flag replaces file-based initialisation.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers.
- ZERO_REG, 1, 1 = register 0 reads as 0 and ignores writes; 0 = register 0 is an ordinary register.
- CLR_VAL, 0, value (DATA_W bits) written to every register by the clear engine.

Ports:
- Clk  input  1  system clock; all state changes on the rising edge.
- Rst_n  input  1  asynchronous, active-low reset.
- Run  input  1  core enable; gates external reads and writes.
- Rs  input  ADDR_W  read address A.
- Rt  input  ADDR_W  read address B; write address when RegDst=0.
- Rd  input  ADDR_W  write address when RegDst=1.
- RegDst  input  1  write-address select (0 = Rt, 1 = Rd).
- RegWr  input  1  write request.
- Overflow  input  1  ALU overflow; squashes the write.
- busW  input  DATA_W  write data.
- busA  output  DATA_W  read data A.
- busB  output  DATA_W  read data B.
- Ready  output  1  clear engine finished; file usable.

Behaviour:
- Reset: Rst_n low asynchronously forces state CLEAR, clear counter = 0, Ready = 0. busA and busB read 0 while Ready = 0.
- State machine, two states:
  - CLEAR: each posedge writes CLR_VAL to Mem[counter], then counter += 1. After the write at counter = DEPTH-1, go to READY and set Ready = 1. CLEAR therefore lasts exactly DEPTH cycles after reset release.
  - READY: stays there until the next reset.
- Clear behaviour does not depend on Run, RegWr or Overflow. External writes are ignored during CLEAR.
- Reset asserted mid-clear or in READY restarts CLEAR from address 0.
- Write address: Rw = RegDst ? Rd : Rt.
- Write enable: we = Ready & Run & RegWr & ~Overflow & ~(ZERO_REG & (Rw == 0)).
  - When we = 1, Mem[Rw] <= busW on posedge Clk.
  - Single-cycle latency: the new value is visible on a read port from the cycle after the edge.
- Reads are combinational from Rs and Rt:
  - If Run = 0 or Ready = 0, the output is 0.
  - If ZERO_REG = 1 and the address is 0, the output is 0.
  - Otherwise the output is Mem[address].
- Simultaneous read and write to the same address with bypass disabled: the read returns the old value until the edge.
- Rs == Rt: both buses return the same value.
- Counter width is ADDR_W+1 so the terminal count is detected without wrap. The counter holds in READY.

Optional Feature:
- Macro: REG_FILE_BYPASS_EN.
- Defined: when we = 1 and Rw equals Rs (or Rt), busA (or busB) combinationally returns busW in the same cycle.
  - The ZERO_REG rule still wins.
  - Bypass is active only when the output is not forced to 0 by Run = 0 or Ready = 0.
- Undefined: no forwarding; the read returns the stored value until the write edge.

Decomposition:
- Shared package (reg_file_pkg):
  - state encoding: typedef rf_state_t {RF_CLEAR, RF_READY};
  - default DATA_W and ADDR_W constants;
  - localparam DEPTH derivation.
- One sub-module: reuse the existing parametrised mux2to1 (k = ADDR_W) for the RegDst write-address select. All other logic lives in param_reg_file.

Test Plan:
1. Release Rst_n with DATA_W=32, ADDR_W=5, CLR_VAL=0:
   - Ready = 0 for exactly 32 cycles, then 1.
   - During the clear, busA = 0 with Rs=5, Run=1.
2. After Ready, set Run=1, RegWr=1, RegDst=1, Rd=3, busW=32'hDEADBEEF.
   - Next cycle with Rs=3: busA = DEADBEEF.
   - RegDst=0, Rt=4, busW=32'h12345678 then writes reg 4, checked via busB.
3. Write Rd=7, busW=32'hAAAA5555 with Overflow=1 -> reg 7 still reads 0. Repeat with Overflow=0 -> reads AAAA5555.
4. ZERO_REG=1: write Rd=0, busW=32'hFFFFFFFF -> busA with Rs=0 reads 0. Run=0 forces busA = busB = 0 for any address.
5. Assert Rst_n low at clear cycle 10, release -> Ready rises 32 cycles after release. Reg 3, previously DEADBEEF, reads 0.
6. With REG_FILE_BYPASS_EN defined, write Rd=9, busW=32'h0BADF00D while Rs=9 -> busA = 0BADF00D in the same cycle. Without the macro, busA = 0 in that cycle and 0BADF00D in the next.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared types and sizing for the parametrised register file.
// Optional same-cycle forwarding in param_reg_file is enabled by REG_FILE_BYPASS_EN.
package reg_file_pkg;

    localparam int unsigned RF_DATA_W = 32;
    localparam int unsigned RF_ADDR_W = 5;

    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_READY = 1'b1
    } rf_state_t;

    // Number of registers addressed by an aw-bit address.
    function automatic int unsigned rf_depth(input int unsigned aw);
        return 32'(1) << aw;
    endfunction

    localparam int unsigned RF_DEPTH = rf_depth(RF_ADDR_W);

endpackage

// File: rtl/mux2to1.sv
// Parametrised k-bit two-input multiplexer: y = sel ? in1 : in0.
module mux2to1 #(
    parameter int unsigned k = 32
) (
    input  logic [k-1:0] in0,
    input  logic [k-1:0] in1,
    input  logic         sel,
    output logic [k-1:0] y
);

    assign y = sel ? in1 : in0;

endmodule

// File: rtl/param_reg_file.sv
// Parametrised 2-read/1-write register file with a post-reset clear engine.
// Define REG_FILE_BYPASS_EN to forward busW to a read port that hits the write address.
module param_reg_file
    import reg_file_pkg::*;
#(
    parameter int unsigned       DATA_W   = RF_DATA_W,
    parameter int unsigned       ADDR_W   = RF_ADDR_W,
    parameter bit                ZERO_REG = 1'b1,
    parameter logic [DATA_W-1:0] CLR_VAL  = '0
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              Run,
    input  logic [ADDR_W-1:0] Rs,
    input  logic [ADDR_W-1:0] Rt,
    input  logic [ADDR_W-1:0] Rd,
    input  logic              RegDst,
    input  logic              RegWr,
    input  logic              Overflow,
    input  logic [DATA_W-1:0] busW,
    output logic [DATA_W-1:0] busA,
    output logic [DATA_W-1:0] busB,
    output logic              Ready
);

    localparam int unsigned       DEPTH    = rf_depth(ADDR_W);
    localparam int unsigned       CNT_W    = ADDR_W + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEPTH - 1);

    rf_state_t          state;
    logic [CNT_W-1:0]   clr_cnt;
    logic               ready_q;
    logic [ADDR_W-1:0]  rw;
    logic               we;
    logic [DATA_W-1:0]  mem [DEPTH];

    mux2to1 #(.k(ADDR_W)) u_rw_mux (
        .in0 (Rt),
        .in1 (Rd),
        .sel (RegDst),
        .y   (rw)
    );

    assign we    = ready_q & Run & RegWr & ~Overflow & ~(ZERO_REG & (rw == '0));
    assign Ready = ready_q;

    // Clear engine: one register per cycle, then park in READY until reset.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state   <= RF_CLEAR;
            clr_cnt <= '0;
            ready_q <= 1'b0;
        end else begin
            case (state)
                RF_CLEAR: begin
                    clr_cnt <= clr_cnt + CNT_W'(1);
                    if (clr_cnt == LAST_CNT) begin
                        state   <= RF_READY;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state   <= RF_READY;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    // Storage has no reset; the clear engine owns the write port until READY.
    always_ff @(posedge Clk) begin
        if (state == RF_CLEAR) begin
            mem[clr_cnt[ADDR_W-1:0]] <= CLR_VAL;
        end else if (we) begin
            mem[rw] <= busW;
        end
    end

    always_comb begin
        busA = '0;
        busB = '0;
        if (ready_q && Run) begin
            if (!(ZERO_REG && (Rs == '0))) begin
                busA = mem[Rs];
            end
            if (!(ZERO_REG && (Rt == '0))) begin
                busB = mem[Rt];
            end
`ifdef REG_FILE_BYPASS_EN
            // we already excludes a hardwired register 0, so zero still wins.
            if (we && (rw == Rs)) begin
                busA = busW;
            end
            if (we && (rw == Rt)) begin
                busB = busW;
            end
`endif
        end
    end

endmodule

// File: tb/tb_param_reg_file.sv
// Scoreboard bench for param_reg_file (default parameters); follows REG_FILE_BYPASS_EN.
module tb_param_reg_file;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;

`ifdef REG_FILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              Clk;
    logic              Rst_n;
    logic              Run;
    logic [ADDR_W-1:0] Rs;
    logic [ADDR_W-1:0] Rt;
    logic [ADDR_W-1:0] Rd;
    logic              RegDst;
    logic              RegWr;
    logic              Overflow;
    logic [DATA_W-1:0] busW;
    logic [DATA_W-1:0] busA;
    logic [DATA_W-1:0] busB;
    logic              Ready;

    param_reg_file dut (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .Run      (Run),
        .Rs       (Rs),
        .Rt       (Rt),
        .Rd       (Rd),
        .RegDst   (RegDst),
        .RegWr    (RegWr),
        .Overflow (Overflow),
        .busW     (busW),
        .busA     (busA),
        .busB     (busB),
        .Ready    (Ready)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct packed {
        logic              ca;
        logic              cb;
        logic              cr;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic              r;
    } exp_t;

    exp_t  exp_q [$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;

    task automatic expect_out(input string nm, input bit ca, input logic [DATA_W-1:0] a,
                              input bit cb, input logic [DATA_W-1:0] b,
                              input bit cr, input logic r);
        exp_t e;
        e.ca = ca; e.cb = cb; e.cr = cr;
        e.a  = a;  e.b  = b;  e.r  = r;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Monitor: outputs are settled mid-cycle, so compare on the falling edge.
    always @(negedge Clk) begin
        if (exp_q.size() > 0) begin
            exp_t  e;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            if (e.cr) begin
                checks++;
                if (Ready !== e.r) begin
                    errors++;
                    $display("FAIL %s Ready: got %b want %b", nm, Ready, e.r);
                end
            end
            if (e.ca) begin
                checks++;
                if (busA !== e.a) begin
                    errors++;
                    $display("FAIL %s busA: got %h want %h", nm, busA, e.a);
                end
            end
            if (e.cb) begin
                checks++;
                if (busB !== e.b) begin
                    errors++;
                    $display("FAIL %s busB: got %h want %h", nm, busB, e.b);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic wr(input logic dst, input logic [ADDR_W-1:0] addr,
                      input logic [DATA_W-1:0] data, input logic ovf);
        RegDst   = dst;
        RegWr    = 1'b1;
        Overflow = ovf;
        busW     = data;
        if (dst) Rd = addr;
        else     Rt = addr;
    endtask

    task automatic idle();
        RegWr    = 1'b0;
        Overflow = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        Rst_n = 1'b0; Run = 1'b1; Rs = 5'd5; Rt = 5'd0; Rd = 5'd0;
        RegDst = 1'b0; RegWr = 1'b0; Overflow = 1'b0; busW = '0;

        // Reset state
        cyc();
        expect_out("reset", 1, 32'h0, 1, 32'h0, 1, 1'b0);
        cyc();
        Rst_n = 1'b1;

        // Clear lasts exactly 32 cycles; a write attempt mid-clear must be dropped
        for (int k = 1; k <= 32; k++) begin
            cyc();
            if (k == 20) wr(1'b1, 5'd2, 32'h0000_0055, 1'b0);
            if (k == 21) idle();
            expect_out($sformatf("clear%0d", k), 1, 32'h0, 0, 32'h0, 1, (k == 32));
        end

        // Write via Rd, read back on busA
        cyc();
        Rs = 5'd3;
        wr(1'b1, 5'd3, 32'hDEAD_BEEF, 1'b0);
        expect_out("wr_rd3_same", 1, BYP ? 32'hDEAD_BEEF : 32'h0, 0, 32'h0, 1, 1'b1);
        cyc();
        idle();
        expect_out("rd3", 1, 32'hDEAD_BEEF, 0, 32'h0, 0, 1'b0);

        // Write via Rt, read back on busB
        cyc();
        wr(1'b0, 5'd4, 32'h1234_5678, 1'b0);
        expect_out("wr_rt4_same", 0, 32'h0, 1, BYP ? 32'h1234_5678 : 32'h0, 0, 1'b0);
        cyc();
        idle();
        expect_out("rt4", 1, 32'hDEAD_BEEF, 1, 32'h1234_5678, 0, 1'b0);
        cyc();
        Rs = 5'd4;
        expect_out("rs_eq_rt", 1, 32'h1234_5678, 1, 32'h1234_5678, 0, 1'b0);

        // Clear-time write to reg 2 was ignored
        cyc();
        Rs = 5'd2;
        expect_out("clr_wr_ignored", 1, 32'h0, 0, 32'h0, 0, 1'b0);

        // Overflow squashes the write; retry without overflow lands
        cyc();
        Rs = 5'd7;
        wr(1'b1, 5'd7, 32'hAAAA_5555, 1'b1);
        expect_out("ovf_same", 1, 32'h0, 0, 32'h0, 0, 1'b0);
        cyc();
        idle();
        expect_out("ovf_after", 1, 32'h0, 0, 32'h0, 0, 1'b0);
        cyc();
        wr(1'b1, 5'd7, 32'hAAAA_5555, 1'b0);
        expect_out("nov_same", 1, BYP ? 32'hAAAA_5555 : 32'h0, 0, 32'h0, 0, 1'b0);
        cyc();
        idle();
        expect_out("nov_after", 1, 32'hAAAA_5555, 0, 32'h0, 0, 1'b0);

        // Register 0 is hardwired to zero
        cyc();
        Rs = 5'd0;
        wr(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0);
        expect_out("zero_same", 1, 32'h0, 0, 32'h0, 0, 1'b0);
        cyc();
        idle();
        Rt = 5'd0;
        expect_out("zero_after", 1, 32'h0, 1, 32'h0, 0, 1'b0);

        // Run=0 blanks reads and blocks writes
        cyc();
        Run = 1'b0; Rs = 5'd3; Rt = 5'd4;
        wr(1'b1, 5'd5, 32'hCAFE_F00D, 1'b0);
        expect_out("run0", 1, 32'h0, 1, 32'h0, 1, 1'b1);
        cyc();
        idle();
        Run = 1'b1; Rs = 5'd5;
        expect_out("run0_nowr", 1, 32'h0, 1, 32'h1234_5678, 0, 1'b0);

        // Same-cycle read of the write address
        cyc();
        Rs = 5'd9;
        wr(1'b1, 5'd9, 32'h0BAD_F00D, 1'b0);
        expect_out("byp_same", 1, BYP ? 32'h0BAD_F00D : 32'h0, 0, 32'h0, 0, 1'b0);
        cyc();
        idle();
        expect_out("byp_after", 1, 32'h0BAD_F00D, 0, 32'h0, 0, 1'b0);

        // Reset from READY, then again at clear cycle 10
        cyc();
        Rst_n = 1'b0; Rs = 5'd3;
        expect_out("rst_ready", 1, 32'h0, 0, 32'h0, 1, 1'b0);
        cyc();
        Rst_n = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            cyc();
            expect_out($sformatf("clr_a%0d", k), 1, 32'h0, 0, 32'h0, 1, 1'b0);
        end
        Rst_n = 1'b0;
        expect_out("rst_mid", 1, 32'h0, 0, 32'h0, 1, 1'b0);
        cyc();
        Rst_n = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            cyc();
            expect_out($sformatf("clr_b%0d", k), 0, 32'h0, 0, 32'h0, 1, (k == 32));
        end
        cyc();
        Rt = 5'd4;
        expect_out("post_clr_34", 1, 32'h0, 1, 32'h0, 1, 1'b1);
        cyc();
        Rs = 5'd7; Rt = 5'd9;
        expect_out("post_clr_79", 1, 32'h0, 1, 32'h0, 0, 1'b0);

        // Let the monitor drain
        @(negedge Clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
